ifu_fetch: RTL and testbench

Multi-cycle instruction fetch stage that sits directly upstream of the instruction decoder in the npc core. It owns the PC register and issues one word fetch at a time over a request/response memory port with variable latency. Each fetched instruction and its PC are presented to the decoder through a valid/ready handshake. The stage then waits for the execute/writeback side to return the next PC before starting the following fetch (one instruction in flight, no speculation).

---
 rtl/ifu_fetch.sv | 140 ++++++++++++++
 tb/tb_ifu_fetch.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: multi-cycle instruction fetch stage for the npc core.
// Owns the PC, issues one word fetch at a time over a request/response port,
// hands the fetched word to the decoder, then waits for the next PC.
//
// Handshakes: a transfer happens on a rising edge where both the valid and
// the ready of a pair are high (mem_req_valid/mem_req_ready and
// inst_valid/inst_ready). A valid, once raised, stays high with stable
// payload until the transfer. mem_resp_valid and next_pc_valid are
// single-cycle qualifiers with no ready; they are acted on only in the
// states that expect them.
module ifu_fetch #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned      TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [WIDTH-1:0] mem_req_addr,
  input  logic             mem_resp_valid,
  input  logic [31:0]      mem_resp_data,
  input  logic             mem_resp_err,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [WIDTH-1:0] inst_pc,
  output logic             inst_fault,
  input  logic             next_pc_valid,
  input  logic [WIDTH-1:0] next_pc
);

  // The WAIT counter only has to reach TIMEOUT-1: it starts at 0 in the
  // first WAIT cycle, so the TIMEOUT-th WAIT cycle sees TIMEOUT-1.
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_EXEC = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic: fetch sequencing, response capture, timeout and
  // the misaligned-next-PC shortcut straight back to HOLD.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;

    // After a timeout the abandoned response may still arrive in any
    // state; the first one seen is swallowed here.
    if (drop_q && mem_resp_valid) begin
      drop_d = 1'b0;
    end

    case (state_q)
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A genuine response wins over an expiry in the same cycle.
        if (mem_resp_valid && !drop_q) begin
          inst_d  = mem_resp_err ? 32'd0 : mem_resp_data;
          fault_d = mem_resp_err;
          state_d = S_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          inst_d  = 32'd0;
          fault_d = 1'b1;
          drop_d  = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (next_pc_valid) begin
          pc_d = next_pc;
          // A misaligned target is reported without touching memory.
          if (next_pc[1:0] != 2'b00) begin
            inst_d  = 32'd0;
            fault_d = 1'b1;
            state_d = S_HOLD;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Handshake valids decode from the state and are masked during reset.
  always_comb begin
    mem_req_valid = !rst && (state_q == S_REQ);
    inst_valid    = !rst && (state_q == S_HOLD);
    mem_req_addr  = pc_q;
    inst_pc       = pc_q;
    inst          = inst_q;
    inst_fault    = fault_q;
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed table, multi-cycle corner sequences and a
// randomized run scored against a transaction-level model of the fetch stage.
module tb_ifu_fetch;

  localparam int unsigned TO      = 4;
  localparam logic [31:0] RST_PC  = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        next_pc_valid;
  logic [31:0] next_pc;

  int checks = 0;
  int errors = 0;

  ifu_fetch #(.WIDTH(32), .RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_err   (mem_resp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .next_pc_valid  (next_pc_valid),
    .next_pc        (next_pc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL global_timeout: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "time limit");
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'd0;
    mem_resp_err   = 1'b0;
    inst_ready     = 1'b0;
    next_pc_valid  = 1'b0;
    next_pc        = 32'd0;
  endtask

  // Pulse reset for two edges, checking the masked valids and the
  // post-reset fetch of RESET_PC.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rst_req_valid_req", mem_req_valid, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_req_valid", mem_req_valid, 1'b1);
    check("post_rst_addr", mem_req_addr, RST_PC);
    check("post_rst_inst_valid", inst_valid, 1'b0);
  endtask

  // Wait (bounded) for a request, check its address, accept it.
  // Returns at the negedge of the first WAIT cycle.
  task automatic accept_req(input logic [31:0] exp_addr);
    int n;
    n = 0;
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", mem_req_valid, 1'b1);
    check("req_addr", mem_req_addr, exp_addr);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("req_single", mem_req_valid, 1'b0);
  endtask

  // Full fetch with a response lat cycles after acceptance.
  // Returns at the negedge of the cycle after the response.
  task automatic do_fetch(input int lat, input logic err, input logic [31:0] data,
                          input logic [31:0] exp_addr);
    accept_req(exp_addr);
    for (int k = 1; k < lat; k++) @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    mem_resp_err   = err;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
  endtask

  // Consume the held instruction and return the next PC.
  task automatic finish_inst(input logic [31:0] npc);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    check("exec_inst_valid", inst_valid, 1'b0);
    check("exec_req_valid", mem_req_valid, 1'b0);
    next_pc_valid = 1'b1;
    next_pc       = npc;
    @(negedge clk);
    next_pc_valid = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] data;
    logic [31:0] npc;
    logic [31:0] exp_inst;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [6];

  // ---------------- scoreboard for random run ----------------
  // {pc[64:33], inst[32:1], fault[0]} per instruction the decoder should see
  logic [64:0] exp_q[$];
  logic [64:0] e;

  int unsigned cyc, resp_at, exec_wait, hs_count, last_hs, lat;
  logic        pending, in_exec, expect_req, rerr, flt;
  logic [31:0] rdata, model_pc, np, exp_pc, hold_inst;

  initial begin
    rst = 1'b1;
    idle_inputs();
    vecs[0] = '{1, 1'b0, 32'h0000_0013, 32'h8000_0004, 32'h0000_0013, 1'b0};
    vecs[1] = '{2, 1'b0, 32'h0010_0093, 32'h8000_0008, 32'h0010_0093, 1'b0};
    vecs[2] = '{3, 1'b1, 32'hdead_beef, 32'h8000_000c, 32'h0000_0000, 1'b1};
    vecs[3] = '{4, 1'b0, 32'hcafe_f00d, 32'h8000_0100, 32'hcafe_f00d, 1'b0};
    vecs[4] = '{1, 1'b1, 32'hffff_ffff, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[5] = '{3, 1'b0, 32'h1234_5678, 32'h8000_0010, 32'h1234_5678, 1'b0};

    repeat (2) @(negedge clk);
    do_reset();
    check("rst_inst", inst, 32'd0);
    check("rst_fault", inst_fault, 1'b0);
    check("rst_pc", inst_pc, RST_PC);

    // Table: latency 1 gives inst_valid two cycles after the request
    // cycle; latency 4 lands on the expiry cycle and must not fault.
    exp_pc = RST_PC;
    for (int i = 0; i < 6; i++) begin
      do_fetch(vecs[i].lat, vecs[i].err, vecs[i].data, exp_pc);
      check("vec_valid", inst_valid, 1'b1);
      check("vec_inst", inst, vecs[i].exp_inst);
      check("vec_fault", inst_fault, vecs[i].exp_fault);
      check("vec_pc", inst_pc, exp_pc);
      finish_inst(vecs[i].npc);
      exp_pc = vecs[i].npc;
    end

    // Backpressure in HOLD.
    do_fetch(2, 1'b0, 32'h00c0_0113, 32'h8000_0010);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", inst_valid, 1'b1);
      check("bp_inst", inst, 32'h00c0_0113);
      check("bp_pc", inst_pc, 32'h8000_0010);
      check("bp_no_req", mem_req_valid, 1'b0);
    end
    finish_inst(32'h8000_0004);

    // Misaligned next PC.
    do_fetch(1, 1'b0, 32'h0000_0013, 32'h8000_0004);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready    = 1'b0;
    next_pc_valid = 1'b1;
    next_pc       = 32'h8000_0002;
    @(negedge clk);
    next_pc_valid = 1'b0;
    check("mis_no_req", mem_req_valid, 1'b0);
    check("mis_valid", inst_valid, 1'b1);
    check("mis_fault", inst_fault, 1'b1);
    check("mis_inst", inst, 32'd0);
    check("mis_pc", inst_pc, 32'h8000_0002);
    finish_inst(32'h8000_0008);

    // Timeout, late response dropped while in HOLD.
    accept_req(32'h8000_0008);
    for (int k = 0; k < 4; k++) begin
      check("to_waiting", inst_valid, 1'b0);
      @(negedge clk);
    end
    check("to_valid", inst_valid, 1'b1);
    check("to_fault", inst_fault, 1'b1);
    check("to_inst", inst, 32'd0);
    check("to_pc", inst_pc, 32'h8000_0008);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1111_1111;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("late_inst", inst, 32'd0);
    check("late_fault", inst_fault, 1'b1);
    finish_inst(32'h8000_0010);
    do_fetch(1, 1'b0, 32'h00a0_0093, 32'h8000_0010);
    check("after_to_inst", inst, 32'h00a0_0093);
    check("after_to_fault", inst_fault, 1'b0);
    check("after_to_pc", inst_pc, 32'h8000_0010);
    finish_inst(32'h8000_0014);

    // Timeout, late response lands in the next WAIT and must not end it.
    accept_req(32'h8000_0014);
    repeat (4) @(negedge clk);
    check("to2_fault", inst_fault, 1'b1);
    finish_inst(32'h8000_0018);
    accept_req(32'h8000_0018);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h2222_2222;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("drop_keeps_wait", inst_valid, 1'b0);
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h00b0_0193;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("drop_real_valid", inst_valid, 1'b1);
    check("drop_real_inst", inst, 32'h00b0_0193);
    check("drop_real_fault", inst_fault, 1'b0);
    finish_inst(32'h8000_001c);

    // Reset during WAIT, then during HOLD.
    accept_req(32'h8000_001c);
    do_reset();
    do_fetch(1, 1'b0, 32'h0000_0013, RST_PC);
    check("hold_before_rst", inst_valid, 1'b1);
    do_reset();

    // ---------------- randomized run ----------------
    cyc = 0; pending = 1'b0; in_exec = 1'b0; expect_req = 1'b1;
    model_pc = RST_PC; hs_count = 0; last_hs = 0; exec_wait = 0;
    resp_at = 0; rdata = 0; rerr = 0;
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      mem_resp_data = $urandom;
      mem_resp_err  = 1'($urandom_range(0, 1));

      // memory response: scheduled one, or noise when nothing is owed
      if (pending && cyc == resp_at) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = rdata;
        mem_resp_err   = rerr;
        pending        = 1'b0;
      end else if (!pending && $urandom_range(0, 7) == 0) begin
        mem_resp_valid = 1'b1;
      end

      // next PC: only once the memory side is quiet
      if (in_exec) begin
        if (exec_wait > 0) exec_wait--;
        else if (!pending) begin
          np = RST_PC + ($urandom_range(0, 255) << 2);
          if ($urandom_range(0, 5) == 0) np[1:0] = 2'($urandom_range(1, 3));
          next_pc_valid = 1'b1;
          next_pc       = np;
          model_pc      = np;
          in_exec       = 1'b0;
          if (np[1:0] != 2'b00) exp_q.push_back({np, 32'd0, 1'b1});
          else expect_req = 1'b1;
        end
      end else if ($urandom_range(0, 4) == 0) begin
        next_pc_valid = 1'b1;
        next_pc       = $urandom;
      end

      // request side
      if (mem_req_valid) begin
        check("rand_req_expected", expect_req, 1'b1);
        if (expect_req && $urandom_range(0, 3) != 0) begin
          check("rand_req_addr", mem_req_addr, model_pc);
          mem_req_ready = 1'b1;
          lat     = $urandom_range(1, 7);
          rerr    = ($urandom_range(0, 7) == 0);
          rdata   = $urandom;
          pending = 1'b1;
          resp_at = cyc + lat;
          expect_req = 1'b0;
          flt = rerr || (lat > TO);
          exp_q.push_back({model_pc, flt ? 32'd0 : rdata, flt});
        end
      end

      // decoder side
      if (inst_valid) begin
        check("rand_exp_avail", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          check("rand_pc", inst_pc, e[64:33]);
          check("rand_inst", inst, e[32:1]);
          check("rand_fault", inst_fault, e[0]);
          if ($urandom_range(0, 2) != 0) begin
            inst_ready = 1'b1;
            void'(exp_q.pop_front());
            in_exec   = 1'b1;
            exec_wait = $urandom_range(0, 3);
            hs_count++;
            last_hs   = cyc;
          end
        end
      end

      if (cyc - last_hs > 80) begin
        check("rand_progress_stall", 1'b0, 1'b1);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    idle_inputs();
    check("rand_enough_insts", (hs_count > 100), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
